// File: rtl/button_group_arbiter_pkg.sv
// Shared types and helpers for button-group arbitration.
package button_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } grp_state_t;

    localparam int unsigned BTN_GROUP_N = 4;

    // Widest request vector rr_pick accepts; narrower groups zero-extend.
    localparam int unsigned RR_MAX_N = 32;
    localparam int unsigned RR_IDXW  = $clog2(RR_MAX_N);

    // Round-robin pick: first set bit of req scanning ptr, ptr+1, ..., n-1, 0, ...
    // Returns 0 when req has no set bit among the low n bits.
    function automatic int unsigned rr_pick(
        input logic [RR_MAX_N-1:0] req,
        input int unsigned         ptr,
        input int unsigned         n = BTN_GROUP_N
    );
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = 0;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_N; k++) begin
            if (k < n && !found) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[RR_IDXW-1:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/button_group_arbiter_if.sv
// Button inputs and selection outputs of one radio-button group.
interface button_group_arbiter_if
    import button_pkg::*;
#(
    parameter int unsigned N    = BTN_GROUP_N,
    parameter int unsigned IDXW = $clog2(N)
);
    logic [N-1:0]    button;
    logic            lock;
    logic [N-1:0]    active;
    logic [IDXW-1:0] active_idx;
    logic            active_valid;
    logic            changed;

    // Side that owns the buttons and consumes the selection.
    modport master (
        output button,
        output lock,
        input  active,
        input  active_idx,
        input  active_valid,
        input  changed
    );

    // The arbiter itself.
    modport slave (
        input  button,
        input  lock,
        output active,
        output active_idx,
        output active_valid,
        output changed
    );
endinterface

// File: rtl/button_group_arbiter_press_detect.sv
// N-wide rising-edge detector; press is high in the cycle a button is first seen high.
module press_detect #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] button,
    output logic [N-1:0] press
);
    logic [N-1:0] prev;

    // Edge history; reset also loads the live levels so held buttons are not presses.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= button;
        end else begin
            prev <= button;
        end
    end

    // Rising edge against the previous sample.
    always_comb begin
        press = button & ~prev;
    end
endmodule

// File: rtl/button_group_arbiter.sv
// Radio-button controller: toggles one exclusive selection across N buttons,
// resolving simultaneous presses with a round-robin pointer.
module button_group_arbiter
    import button_pkg::*;
#(
    parameter int unsigned N    = BTN_GROUP_N,
    parameter int unsigned IDXW = $clog2(N)
) (
    input logic                   clk,
    input logic                   rst,
    button_group_arbiter_if.slave bus
);
    localparam logic [N-1:0] ONE = N'(1);

    grp_state_t      state;
    logic [IDXW-1:0] rr_ptr;
    logic [N-1:0]    press;
    logic [N-1:0]    eff_press;
    logic [N-1:0]    cand;
    logic [IDXW-1:0] grant;
    logic [IDXW-1:0] next_ptr;

    press_detect #(.N(N)) u_press_detect (
        .clk    (clk),
        .rst    (rst),
        .button (bus.button),
        .press  (press)
    );

    // Gate presses with lock, keep only presses on non-selected buttons, pick a winner.
    always_comb begin
        eff_press = bus.lock ? '0 : press;
        cand      = eff_press & ~bus.active;
        grant     = IDXW'(rr_pick(RR_MAX_N'(cand), 32'(rr_ptr), N));
        next_ptr  = (grant == IDXW'(N - 1)) ? '0 : grant + 1'b1;
    end

    // Selection FSM with registered outputs; a switch outranks a same-cycle deselect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            bus.active       <= '0;
            bus.active_idx   <= '0;
            bus.active_valid <= 1'b0;
            bus.changed      <= 1'b0;
        end else begin
            bus.changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (cand != '0) begin
                        state            <= ACTIVE;
                        rr_ptr           <= next_ptr;
                        bus.active       <= ONE << grant;
                        bus.active_idx   <= grant;
                        bus.active_valid <= 1'b1;
                        bus.changed      <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cand != '0) begin
                        rr_ptr           <= next_ptr;
                        bus.active       <= ONE << grant;
                        bus.active_idx   <= grant;
                        bus.active_valid <= 1'b1;
                        bus.changed      <= 1'b1;
                    end else if ((eff_press & bus.active) != '0) begin
                        state            <= IDLE;
                        bus.active       <= '0;
                        bus.active_idx   <= '0;
                        bus.active_valid <= 1'b0;
                        bus.changed      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
